// File: rtl/waveform_generator_if.sv
// Control and sample bus of the waveform generator.
// The master drives the strobes and the select; the slave returns the sample stream.
interface waveform_generator_if;
    logic       en;
    logic       init;
    logic [2:0] wsel;
    logic [7:0] wave;
    logic       wave_vld;
    logic       pwm_out;

    modport master (output en, init, wsel, input wave, wave_vld, pwm_out);
    modport slave  (input en, init, wsel, output wave, wave_vld, pwm_out);
endinterface

// File: rtl/waveform_generator.sv
// Waveform generator: an 8-bit phase accumulator and an up/down triangle counter
// advance on each en strobe. The selected waveform is registered with a one-cycle
// valid pulse, and a PWM rendering is produced from a free-running counter.
// The select only changes on init or on a phase wrap, so a period is never torn.
module waveform_generator (
    input  logic                 clk,
    input  logic                 rst,
    waveform_generator_if.slave  bus
);

    typedef enum logic {
        ST_UP   = 1'b0,
        ST_DOWN = 1'b1
    } tri_state_e;

    logic [7:0] phase_q,   phase_d;
    logic [7:0] tri_q,     tri_d;
    tri_state_e state_q,   state_d;
    logic [2:0] asel_q,    asel_d;
    logic [7:0] wave_q,    wave_d;
    logic       vld_q,     vld_d;
    logic [7:0] pwm_cnt_q, pwm_cnt_d;
    logic       pwm_out_q, pwm_out_d;

    // Map the post-update phase, triangle value and select to an output sample.
    function automatic logic [7:0] sample_of(input logic [7:0] ph,
                                             input logic [7:0] tv,
                                             input logic [2:0] sel);
        logic [7:0] s;
        s = 8'h00;
        case (sel)
            3'b000:  s = ph;
            3'b001:  s = ~ph;
            3'b010:  s = tv;
            3'b011:  s = ph[7] ? 8'h00 : 8'hFF;
            3'b100:  s = {ph[7:5], 5'b00000};
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    // Next-state logic: init restarts everything, otherwise en advances one step.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        phase_d   = phase_q;
        tri_d     = tri_q;
        state_d   = state_q;
        asel_d    = asel_q;
        wave_d    = wave_q;
        vld_d     = 1'b0;
        pwm_cnt_d = pwm_cnt_q + 8'd1;
        pwm_out_d = (pwm_cnt_q < wave_q);

        if (bus.init) begin
            phase_d   = 8'd0;
            tri_d     = 8'd0;
            state_d   = ST_UP;
            asel_d    = bus.wsel;
            wave_d    = 8'd0;
            pwm_cnt_d = 8'd0;
        end else if (bus.en) begin
            phase_d = phase_q + 8'd1;
            if (phase_q == 8'hFF) begin
                asel_d = bus.wsel;
            end

            if (state_q == ST_UP) begin
                tri_d = tri_q + 8'd1;
                if (tri_q == 8'd254) begin
                    state_d = ST_DOWN;
                end
            end else begin
                tri_d = tri_q - 8'd1;
                if (tri_q == 8'd1) begin
                    state_d = ST_UP;
                end
            end

            wave_d = sample_of(phase_d, tri_d, asel_d);
            vld_d  = 1'b1;
        end
    end

    // State register with asynchronous active-low reset clearing every register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q   <= 8'd0;
            tri_q     <= 8'd0;
            state_q   <= ST_UP;
            asel_q    <= 3'b000;
            wave_q    <= 8'd0;
            vld_q     <= 1'b0;
            pwm_cnt_q <= 8'd0;
            pwm_out_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            phase_q   <= phase_d;
            tri_q     <= tri_d;
            state_q   <= state_d;
            asel_q    <= asel_d;
            wave_q    <= wave_d;
            vld_q     <= vld_d;
            pwm_cnt_q <= pwm_cnt_d;
            pwm_out_q <= pwm_out_d;
        end
    end

    assign bus.wave     = wave_q;
    assign bus.wave_vld = vld_q;
    assign bus.pwm_out  = pwm_out_q;

endmodule

// File: tb/tb_waveform_generator.sv
// Self-checking bench for waveform_generator: a behavioural model pushes expected
// samples into a queue as en is driven; a monitor pops them on each wave_vld.
module tb_waveform_generator;

    logic clk;
    logic rst;
    waveform_generator_if bus ();

    waveform_generator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural reference model
    logic [7:0] m_phase;
    logic [7:0] m_tri;
    logic       m_up;
    logic [2:0] m_asel;
    logic [7:0] exp_q[$];

    task automatic model_reset(input logic [2:0] sel);
        m_phase = 8'd0;
        m_tri   = 8'd0;
        m_up    = 1'b1;
        m_asel  = sel;
    endtask

    function automatic logic [7:0] model_sample();
        case (m_asel)
            3'b000:  return m_phase;
            3'b001:  return 8'd255 - m_phase;
            3'b010:  return m_tri;
            3'b011:  return (m_phase < 8'd128) ? 8'd255 : 8'd0;
            3'b100:  return m_phase & 8'hE0;
            default: return 8'd0;
        endcase
    endfunction

    task automatic model_step();
        if (m_phase == 8'd255) m_asel = bus.wsel;
        m_phase = m_phase + 8'd1;
        if (m_up) begin
            m_tri = m_tri + 8'd1;
            if (m_tri == 8'd255) m_up = 1'b0;
        end else begin
            m_tri = m_tri - 8'd1;
            if (m_tri == 8'd0) m_up = 1'b1;
        end
        exp_q.push_back(model_sample());
    endtask

    // Monitor: wave_vld must follow each sampled en (without init) by one clk.
    logic en_s, init_s, rst_s;
    logic mon_on = 1'b0;
    always @(posedge clk) begin
        en_s   = bus.en;
        init_s = bus.init;
        rst_s  = rst;
    end

    always @(negedge clk) begin
        if (mon_on) begin
            check("wave_vld", bus.wave_vld, en_s && !init_s && rst_s && rst);
            if (bus.wave_vld) begin
                if (exp_q.size() == 0) check("sb_underflow", 1, 0);
                else                   check("wave", bus.wave, exp_q.pop_front());
            end
        end
    end

    // Stimulus helpers; all drive on the falling edge.
    task automatic pulse_en(input int n);
        for (int i = 0; i < n; i++) begin
            bus.en = 1'b1;
            model_step();
            @(negedge clk);
        end
        bus.en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_init(input logic [2:0] sel, input logic with_en);
        bus.init = 1'b1;
        bus.en   = with_en;
        bus.wsel = sel;
        model_reset(sel);
        @(negedge clk);
        bus.init = 1'b0;
        bus.en   = 1'b0;
        check("init_wave", bus.wave, 0);
    endtask

    int highs;

    initial begin
        bus.en   = 1'b0;
        bus.init = 1'b0;
        bus.wsel = 3'b000;
        rst      = 1'b1;
        #1 rst   = 1'b0;
        model_reset(3'b000);
        idle(3);
        check("rst_wave", bus.wave, 0);
        check("rst_vld", bus.wave_vld, 0);
        check("rst_pwm", bus.pwm_out, 0);
        mon_on = 1'b1;

        // Release with en in the same cycle: first edge after release honours it.
        rst    = 1'b1;
        bus.en = 1'b1;
        model_step();
        @(negedge clk);
        bus.en = 1'b0;
        idle(1);
        pulse_en(1); idle(2);
        pulse_en(1); idle(2);
        check("saw_3", bus.wave, 3);

        // Triangle over a full 510-step period, consecutive en.
        do_init(3'b010, 1'b0);
        pulse_en(255);
        check("tri_peak", bus.wave, 255);
        pulse_en(255);
        check("tri_end", bus.wave, 0);
        pulse_en(1);
        check("tri_up_again", bus.wave, 1);

        // Select change mid-period only takes effect at the wrap.
        do_init(3'b000, 1'b0);
        pulse_en(100);
        bus.wsel = 3'bxxx;
        idle(3);
        bus.wsel = 3'b001;
        pulse_en(155);
        check("saw_top", bus.wave, 255);
        pulse_en(1);
        check("wrap_rev", bus.wave, 255);
        pulse_en(1);
        check("rev_next", bus.wave, 254);

        // Square, staircase and reserved selections.
        do_init(3'b011, 1'b0);
        pulse_en(200);
        do_init(3'b100, 1'b0);
        pulse_en(70);
        check("stair", bus.wave, 8'h40);
        do_init(3'b101, 1'b0);
        pulse_en(5);
        check("reserved", bus.wave, 0);

        // init wins over a concurrent en.
        do_init(3'b000, 1'b0);
        pulse_en(10);
        idle(1);
        do_init(3'b000, 1'b1);
        check("init_en_vld", bus.wave_vld, 0);
        pulse_en(1);
        check("after_init_en", bus.wave, 1);

        // PWM duty at wave=64 over two 256-clk windows, then at wave=0.
        do_init(3'b000, 1'b0);
        pulse_en(64);
        idle(2);
        for (int w = 0; w < 2; w++) begin
            highs = 0;
            for (int i = 0; i < 256; i++) begin
                @(negedge clk);
                if (bus.pwm_out) highs++;
            end
            check("pwm_64", highs, 64);
        end
        do_init(3'b000, 1'b0);
        idle(2);
        highs = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (bus.pwm_out) highs++;
        end
        check("pwm_0", highs, 0);

        // Asynchronous reset mid-triangle at tri=200 going down.
        do_init(3'b010, 1'b0);
        pulse_en(310);
        check("tri_200", bus.wave, 200);
        idle(1);
        check("sb_before_rst", exp_q.size(), 0);
        #3 rst = 1'b0;
        #1;
        check("arst_wave", bus.wave, 0);
        check("arst_vld", bus.wave_vld, 0);
        check("arst_pwm", bus.pwm_out, 0);
        model_reset(3'b000);
        @(negedge clk);
        rst = 1'b1;
        idle(1);
        pulse_en(1);
        check("post_rst_first", bus.wave, 1);
        pulse_en(1);
        check("post_rst_second", bus.wave, 2);

        idle(3);
        check("sb_drain", exp_q.size(), 0);
        mon_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/waveform_generator.md
WAVEFORM_GENERATOR -- requirements
Module: waveform_generator

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 SHALL have ports, one per line:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous active-low reset (0 = reset)
- en  input  1  sample-advance strobe, one clk wide; driven by the upstream frequency divider carry-out
- init  input  1  synchronous restart; same pulse that reloads the divider
- wsel  input  3  waveform select request
- wave  output  8  current sample, unsigned, registered
- wave_vld  output  1  one-clk pulse in the cycle wave takes a new value
- pwm_out  output  1  registered PWM rendering of wave

Function
REQ-003 SHALL hold an 8-bit phase counter, incremented by 1 on each en; 255 wraps to 0.
REQ-004 SHALL use an active select register (asel), loaded from wsel only on init, or on the en that wraps phase 255->0; a wsel change at any other time SHALL have no effect until the next wrap.
REQ-005 SHALL hold a triangle FSM with states UP/DOWN and an 8-bit tri counter, advanced on every en regardless of asel:
- UP: tri+1; tri==254 -> next tri=255, state DOWN
- DOWN: tri-1; tri==1 -> next tri=0, state UP
- period 510 en pulses; 0 and 255 each appear once per period.
REQ-006 SHALL compute the next sample from the post-update phase/tri and post-update asel:
- 000 sawtooth = phase
- 001 reverse sawtooth = ~phase
- 010 triangle = tri
- 011 square = 8'hFF if phase[7]==0, else 8'h00
- 100 staircase = {phase[7:5], 5'b00000}
- 101/110/111 reserved = 8'h00
REQ-007 SHALL register wave and assert wave_vld in the clk cycle after the edge that samples en (latency 1 clk); without en, wave holds and wave_vld=0.
REQ-008 SHALL give init priority over en in the same cycle:
- phase=0, tri=0, state=UP, wave=0, pwm counter=0
- asel<=wsel
- wave_vld=0
- the concurrent en is discarded.
REQ-009 SHALL run an 8-bit PWM counter incrementing every clk (free-running, wraps 255->0); pwm_out registered = (pwm_cnt < wave).
REQ-010 SHALL produce a PWM duty of wave/256: wave=0 -> pwm_out constant 0; wave=255 -> high 255 of every 256 clks.
REQ-011 SHALL accept en on consecutive clks; each en advances exactly one step.
REQ-012 SHALL be insensitive to X on en/wsel while init=0 and en=0 (wsel sampled only per REQ-004).

Reset
REQ-013 SHALL, while rst=0, force:
- phase=0, tri=0, state=UP, asel=000
- wave=0, wave_vld=0
- pwm_cnt=0, pwm_out=0
REQ-014 SHALL resume operation on the first rising clk edge after rst deasserts; an en in that cycle SHALL be honoured.
REQ-015 SHALL, on a reset asserted mid-period, discard all state with no partial sample output.

Verification
REQ-016 Scenarios a bench SHALL cover:
- rst=0 then release, wsel=000, 3 en pulses -> wave 1,2,3, each with one wave_vld pulse one clk after its en; no en -> no wave_vld.
- init with wsel=010, then 510 en pulses -> wave 1..255 then 254..0; state DOWN after the 255th pulse, UP after the 510th.
- asel=000, phase=100, wsel changed to 001 -> sawtooth continues to 255; the wrapping en yields wave=~0=255; next en gives 254.
- init and en asserted in the same clk -> phase=0, wave=0, wave_vld stays 0.
- wave held at 64 for 512 clks -> pwm_out high exactly 64 clks in each 256-clk window; wave=0 -> never high.
- rst asserted mid-triangle at tri=200 in DOWN -> all outputs 0 asynchronously; after release first en gives wave=1 in UP (asel=000 gives 1 too).
